// File: rtl/attn_out_collector_4x128.sv
// Collects the attention output stream into a 128x128-bit SRAM at addr = {row, group},
// tracking coverage with a bitmap and flagging duplicate, missing and unarmed beats.
module attn_out_collector_4x128 #(
    parameter int EXPECT_BEATS = 128,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             in_valid,
    input  logic [1:0]       in_row,
    input  logic [4:0]       in_group,
    input  logic [127:0]     in_data,
    input  logic             in_done,
    output logic             O_mem_wr_en,
    output logic [6:0]       O_mem_addr,
    output logic [127:0]     O_mem_din,
    output logic [CNT_W-1:0] beat_count,
    output logic             busy,
    output logic             complete,
    output logic             err_dup,
    output logic             err_missing,
    output logic             err_unarmed
);

    // state   | meaning
    // IDLE    | waiting for arm
    // COLLECT | accepting beats into the write pipeline
    // FLUSH   | last captured beat is being written
    // DONE    | complete pulse, back to IDLE next
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECT_BEATS);

    state_t             state_q,   state_d;
    logic [127:0]       bitmap_q,  bitmap_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               wr_en_q,   wr_en_d;
    logic [6:0]         addr_q,    addr_d;
    logic [127:0]       din_q,     din_d;
    logic               busy_q,    busy_d;
    logic               complete_q, complete_d;
    logic               dup_q,     dup_d;
    logic               missing_q, missing_d;
    logic               unarmed_q, unarmed_d;

    logic [6:0]         beat_addr;

    assign beat_addr = {in_row, in_group};

    always_comb begin
        state_d    = state_q;
        bitmap_d   = bitmap_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        complete_d = 1'b0;
        dup_d      = dup_q;
        missing_d  = missing_q;
        unarmed_d  = unarmed_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    bitmap_d  = '0;
                    count_d   = '0;
                    dup_d     = 1'b0;
                    missing_d = 1'b0;
                    unarmed_d = 1'b0;
                    state_d   = COLLECT;
                end
                // a stray beat on the arming edge is still reported
                if (in_valid) unarmed_d = 1'b1;
            end
            COLLECT: begin
                if (in_valid) begin
                    wr_en_d = 1'b1;
                    addr_d  = beat_addr;
                    din_d   = in_data;
                    if (bitmap_q[beat_addr]) begin
                        dup_d = 1'b1;
                    end else begin
                        bitmap_d[beat_addr] = 1'b1;
                        if (count_q != EXP_CNT) count_d = count_q + 1'b1;
                    end
                end
                // end-of-run is judged on the count including this cycle's beat
                if ((count_d == EXP_CNT) || in_done) state_d = FLUSH;
                if (in_done && (count_d != EXP_CNT)) missing_d = 1'b1;
            end
            FLUSH: begin
                if (in_valid) unarmed_d = 1'b1;
                complete_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (in_valid) unarmed_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == COLLECT) || (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitmap_q   <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            dup_q      <= 1'b0;
            missing_q  <= 1'b0;
            unarmed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            dup_q      <= dup_d;
            missing_q  <= missing_d;
            unarmed_q  <= unarmed_d;
        end
    end

    assign O_mem_wr_en = wr_en_q;
    assign O_mem_addr  = addr_q;
    assign O_mem_din   = din_q;
    assign beat_count  = count_q;
    assign busy        = busy_q;
    assign complete    = complete_q;
    assign err_dup     = dup_q;
    assign err_missing = missing_q;
    assign err_unarmed = unarmed_q;

endmodule
